// File: rtl/simd_adder_pipe.sv
// Lane-partitioned SIMD adder/subtractor feeding a valid/ready pipeline of STAGES registers.
// Stage 0 captures the arithmetic result; later stages only delay {Y, C}.
module simd_adder_pipe #(
    parameter int N      = 32,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        mode,
    input  logic              sub,
    input  logic [N-1:0]      A,
    input  logic [N-1:0]      B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      Y,
    output logic [N/8-1:0]    C
);

    localparam int NB = N / 8;

    logic [N-1:0]    b_eff_w;
    logic [N-1:0]    sum_w;
    logic [NB-1:0]   cflag_w;
    logic [8:0]      byte_sum_w;
    logic            carry_w;
    logic            lane_lsb_w;
    logic            lane_msb_w;

    assign b_eff_w = sub ? ~B : B;

    // Byte-serial carry chain; the chain restarts with `sub` at every lane LSB,
    // which gives both lane isolation and the +1 of two's-complement subtract.
    always_comb begin
        sum_w      = '0;
        cflag_w    = '0;
        carry_w    = 1'b0;
        byte_sum_w = '0;
        lane_lsb_w = 1'b0;
        lane_msb_w = 1'b0;
        for (int k = 0; k < NB; k++) begin
            case (mode)
                2'b00: begin
                    lane_lsb_w = 1'b1;
                    lane_msb_w = 1'b1;
                end
                2'b01: begin
                    lane_lsb_w = ((k % 2) == 0);
                    lane_msb_w = ((k % 2) == 1);
                end
                2'b10: begin
                    lane_lsb_w = ((k % 4) == 0);
                    lane_msb_w = ((k % 4) == 3);
                end
                default: begin
                    lane_lsb_w = (k == 0);
                    lane_msb_w = (k == NB - 1);
                end
            endcase
            if (lane_lsb_w) begin
                carry_w = sub;
            end
            byte_sum_w = {1'b0, A[8*k +: 8]} + {1'b0, b_eff_w[8*k +: 8]} + {8'd0, carry_w};
            sum_w[8*k +: 8] = byte_sum_w[7:0];
            carry_w         = byte_sum_w[8];
            cflag_w[k]      = lane_msb_w & byte_sum_w[8];
        end
    end

    logic [STAGES:0]   ready_w;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] v_in_w;
    logic [N-1:0]      y_q    [STAGES];
    logic [NB-1:0]     c_q    [STAGES];
    logic [N-1:0]      y_in_w [STAGES];
    logic [NB-1:0]     c_in_w [STAGES];

    always_comb begin
        ready_w[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready_w[k] = !valid_q[k] || ready_w[k+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage_in
            if (gi == 0) begin : g_first
                assign v_in_w[gi] = in_valid;
                assign y_in_w[gi] = sum_w;
                assign c_in_w[gi] = cflag_w;
            end else begin : g_delay
                assign v_in_w[gi] = valid_q[gi-1];
                assign y_in_w[gi] = y_q[gi-1];
                assign c_in_w[gi] = c_q[gi-1];
            end
        end
    endgenerate

    // Data registers load only on a real transaction so bubbles leave Y/C untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                y_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (ready_w[k]) begin
                    valid_q[k] <= v_in_w[k];
                    if (v_in_w[k]) begin
                        y_q[k] <= y_in_w[k];
                        c_q[k] <= c_in_w[k];
                    end
                end
            end
        end
    end

    assign in_ready  = ready_w[0];
    assign out_valid = valid_q[STAGES-1];
    assign Y         = y_q[STAGES-1];
    assign C         = c_q[STAGES-1];

endmodule

// File: tb/tb_simd_adder_pipe.sv
// Scoreboard bench for simd_adder_pipe: directed vectors, backpressure, reset, and random traffic
// checked against a lane-by-lane arithmetic model.
module tb_simd_adder_pipe;

    localparam int N      = 32;
    localparam int STAGES = 2;
    localparam int NB     = N / 8;

    logic          clk       = 1'b0;
    logic          rst       = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [1:0]    mode      = 2'b00;
    logic          sub       = 1'b0;
    logic [N-1:0]  A         = '0;
    logic [N-1:0]  B         = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  Y;
    logic [NB-1:0] C;

    typedef struct {
        logic [N-1:0]  y;
        logic [NB-1:0] c;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   rnd_en   = 1'b0;

    simd_adder_pipe #(.N(N), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sub       (sub),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .C         (C)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: split into lanes, do plain unsigned add/sub, carry = overflow or no-borrow.
    function automatic exp_t model(input logic [1:0] m, input logic s,
                                   input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t            e;
        int              w;
        longint unsigned mask, la, lb, r;
        logic            cy;
        w   = (m == 2'b11) ? N : (8 << m);
        e.y = '0;
        e.c = '0;
        mask = (64'd1 << w) - 64'd1;
        for (int off = 0; off < N; off += w) begin
            la = 64'(a >> off) & mask;
            lb = 64'(b >> off) & mask;
            if (s) begin
                cy = (la >= lb);
                r  = (la - lb) & mask;
            end else begin
                r  = la + lb;
                cy = ((r >> w) != 0);
                r  = r & mask;
            end
            e.y = e.y | (N'(r) << off);
            e.c[(off + w) / 8 - 1] = cy;
        end
        return e;
    endfunction

    task automatic send(input logic [1:0] m, input logic s, input logic [N-1:0] a,
                        input logic [N-1:0] b, input exp_t e);
        bit ok;
        mode = m; sub = s; A = a; B = b; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            exp_q.push_back(e);
            $display("issue mode=%0d sub=%0d A=%h B=%h expY=%h expC=%b", m, s, a, b, e.y, e.c);
        end else begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=no_accept required=accept");
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [N-1:0] y, input logic [NB-1:0] c);
        exp_t e;
        e.y = y;
        e.c = c;
        return e;
    endfunction

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on every output transfer and checks stall stability.
    initial begin : monitor
        exp_t          e;
        bit            prev_stall = 1'b0;
        logic [N-1:0]  prev_y = '0;
        logic [NB-1:0] prev_c = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_hold_y", 64'(Y), 64'(prev_y));
                    chk("stall_hold_c", 64'(C), 64'(prev_c));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_output actual=Y_%h required=no_output", Y);
                    end else begin
                        e = exp_q.pop_front();
                        $display("output Y=%h C=%b expY=%h expC=%b", Y, C, e.y, e.c);
                        chk("result_y", 64'(Y), 64'(e.y));
                        chk("result_c", 64'(C), 64'(e.c));
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_y     = Y;
                prev_c     = C;
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_en) begin
            #1 out_ready = (($urandom % 3) != 0);
        end
    end

    initial begin : stimulus
        logic [1:0]   m;
        logic         s;
        logic [N-1:0] a, b;

        #12;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_y", 64'(Y), 64'd0);
        chk("reset_c", 64'(C), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        send(2'b10, 1'b0, 32'hE59F1020, 32'h0, mk(32'hE59F1020, 4'b0000));
        @(negedge clk);
        chk("latency_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_on", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        send(2'b00, 1'b0, 32'h80FF0102, 32'h8001FF03, mk(32'h00000005, 4'b1110));
        send(2'b01, 1'b1, 32'h00050003, 32'h00030005, mk(32'h0002FFFE, 4'b1000));
        send(2'b11, 1'b0, 32'h28A44EAF, 32'hA895D275, mk(32'hD13A2124, 4'b0000));
        send(2'b11, 1'b0, 32'hFFFFFFFF, 32'h00000001, mk(32'h00000000, 4'b1000));
        send(2'b10, 1'b1, 32'h00000000, 32'h00000001, mk(32'hFFFFFFFF, 4'b0000));
        drain();

        // Backpressure: two accepted, third blocked until out_ready returns.
        out_ready = 1'b0;
        send(2'b10, 1'b0, 32'd1, 32'd0, mk(32'd1, 4'b0000));
        send(2'b10, 1'b0, 32'd2, 32'd0, mk(32'd2, 4'b0000));
        mode = 2'b10; sub = 1'b0; A = 32'd3; B = 32'd0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            chk("bp_y_hold", 64'(Y), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_push", 64'(in_ready), 64'd1);
        exp_q.push_back(mk(32'd3, 4'b0000));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_consec_2", 64'(out_valid), 64'd1);
        @(negedge clk);
        chk("bp_consec_3", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Asynchronous reset with two transactions in flight.
        out_ready = 1'b0;
        send(2'b00, 1'b0, 32'h11111111, 32'h22222222, mk(32'h33333333, 4'b0000));
        send(2'b00, 1'b0, 32'h44444444, 32'h55555555, mk(32'h99999999, 4'b0000));
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_y", 64'(Y), 64'd0);
        chk("arst_c", 64'(C), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(2'b01, 1'b0, 32'h7FFF8000, 32'h00018000, model(2'b01, 1'b0, 32'h7FFF8000, 32'h00018000));
        @(negedge clk);
        chk("post_rst_lat_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("post_rst_lat_on", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        rnd_en = 1'b1;
        for (int t = 0; t < 300; t++) begin
            if (($urandom % 4) == 0) begin
                @(posedge clk);
                #1;
            end
            m = 2'($urandom);
            s = 1'($urandom);
            a = $urandom;
            case ($urandom % 4)
                0:       b = ~a;
                1:       b = a;
                default: b = $urandom;
            endcase
            send(m, s, a, b, model(m, s, a, b));
        end
        rnd_en = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("final_idle", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
